// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT + BTB with combinational lookup and trained update.
// Define BP_STATS_EN to build the saturating branch/mispredict counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lookup_pc,
  output logic        pred_taken,
  output logic [15:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_stall,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic [15:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts,
  output logic        err
);
  localparam int TAG_W = 15 - IDX_W;
  logic             v   [ENTRIES];
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [1:0]       ctr [ENTRIES];
  logic [15:0]      tgt [ENTRIES];
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, acc, wr;
  logic [1:0]       u_ctr, new_ctr;
  logic [15:0]      new_tgt;
  assign l_idx = lookup_pc[IDX_W:1];
  assign l_tag = lookup_pc[15:IDX_W+1];
  assign u_idx = upd_pc[IDX_W:1];
  assign u_tag = upd_pc[15:IDX_W+1];
  assign l_hit = v[l_idx] && tag[l_idx] == l_tag;
  assign u_hit = v[u_idx] && tag[u_idx] == u_tag;
  assign pred_taken = l_hit && ctr[l_idx][1];
  assign pred_target = pred_taken ? tgt[l_idx] : lookup_pc + 16'd2;
  assign err = lookup_pc[0] || (upd_valid && upd_pc[0]);
  assign acc = upd_valid && !upd_stall;
  // a miss only allocates on a taken outcome; hits always train
  assign wr = acc && (u_hit || upd_taken);
  assign u_ctr = ctr[u_idx];
  always_comb begin
    new_ctr = u_hit ? (upd_jump ? 2'b11 :
                       upd_taken ? (u_ctr == 2'b11 ? 2'b11 : u_ctr + 2'b01) :
                                   (u_ctr == 2'b00 ? 2'b00 : u_ctr - 2'b01))
                    : (upd_jump ? 2'b11 : 2'b10);
    new_tgt = (upd_jump || upd_taken) ? upd_target : tgt[u_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v[i]   <= 1'b0;
        tag[i] <= '0;
        ctr[i] <= 2'b01;
        tgt[i] <= 16'h0000;
      end
    end else if (wr) begin
      v[u_idx]   <= 1'b1;
      tag[u_idx] <= u_tag;
      ctr[u_idx] <= new_ctr;
      tgt[u_idx] <= new_tgt;
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= 16'h0000;
      stat_mispredicts <= 16'h0000;
    end else if (acc) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (upd_pred_taken != upd_taken && stat_mispredicts != 16'hFFFF)
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = upd_pred_taken;
  assign stat_branches = 16'h0000;
  assign stat_mispredicts = 16'h0000;
`endif
endmodule
